// File: rtl/larson_pkg.sv
// Shared types for the scanning light bar sequencer.
// Holds the scan FSM encoding and the dwell counter width.
package larson_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UP,
    HOLD_HI,
    DOWN,
    HOLD_LO
  } scan_state_t;

  localparam int DWELL_W = 4;

endpackage

// File: rtl/larson_prescaler.sv
// Step prescaler for the light bar sequencer.
// Counts to a live divider value and pulses step for one cycle.
module larson_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             step
);

  logic [DIV_W-1:0] cnt;

  // >= rather than == so a divider lowered below cnt fires at once
  assign step = en && (cnt >= div);

  // Period counter, wraps to zero on each step
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= step ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/larson_scan_ctrl.sv
// Knight-Rider style scan sequencer with endpoint dwell and wrap mode.
// Owns the scan FSM, LED position and dwell counter; outputs registered.
module larson_scan_ctrl
  import larson_pkg::*;
#(
  parameter int N_LEDS = 8,
  parameter int DIV_W  = 16,
  parameter int DWELL  = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic [DIV_W-1:0]          i_div,
  input  logic                      i_mode_wrap,
  output logic [N_LEDS-1:0]         o_leds,
  output logic [$clog2(N_LEDS)-1:0] o_pos,
  output logic                      o_dir,
  output logic                      o_tick,
  output logic                      o_busy
);

  localparam int POS_W = $clog2(N_LEDS);

  localparam logic [POS_W-1:0] P_TOP =
    POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0] P_TOP_M1 =
    POS_W'(N_LEDS - 2);
  localparam logic [POS_W-1:0] P_ONE =
    POS_W'(1);

  localparam bit HAS_DWELL = (DWELL > 0);
  localparam logic [DWELL_W-1:0] DW_INIT =
    DWELL_W'(DWELL > 0 ? DWELL - 1 : 0);

  localparam logic [N_LEDS-1:0] LED0 =
    {{(N_LEDS-1){1'b0}}, 1'b1};

  scan_state_t        state, state_n;
  logic [POS_W-1:0]   pos_q, pos_n;
  logic               dir_n;
  logic [DWELL_W-1:0] dwl_q, dwl_n;
  logic               tick_n;
  logic [N_LEDS-1:0]  leds_n;
  logic               step;
  logic               pre_clr;
  logic               pre_en;

  assign pre_en  = (state != IDLE);
  assign pre_clr = (state == IDLE) || !i_en;

  larson_prescaler #(
    .DIV_W(DIV_W)
  ) u_pre (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .clr  (pre_clr),
    .en   (pre_en),
    .div  (i_div),
    .step (step)
  );

  // Next-state, position, direction and dwell logic
  always_comb begin
    state_n = state;
    pos_n   = pos_q;
    dir_n   = o_dir;
    dwl_n   = dwl_q;
    tick_n  = 1'b0;
    if (!i_en) begin
      state_n = IDLE;
      pos_n   = '0;
      dir_n   = 1'b0;
      dwl_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = UP;
          pos_n   = '0;
          dir_n   = 1'b0;
        end
        UP: if (step) begin
          tick_n = 1'b1;
          if (pos_q != P_TOP) begin
            pos_n = pos_q + 1'b1;
          end else if (i_mode_wrap) begin
            pos_n = '0;
          end else if (HAS_DWELL) begin
            state_n = HOLD_HI;
            dwl_n   = DW_INIT;
          end else begin
            state_n = DOWN;
            pos_n   = P_TOP_M1;
            dir_n   = 1'b1;
          end
        end
        HOLD_HI: if (step) begin
          tick_n = 1'b1;
          if (dwl_q == '0) begin
            state_n = DOWN;
            pos_n   = P_TOP_M1;
            dir_n   = 1'b1;
          end else begin
            dwl_n = dwl_q - 1'b1;
          end
        end
        DOWN: if (step) begin
          tick_n = 1'b1;
          if (pos_q != '0) begin
            pos_n = pos_q - 1'b1;
          end else if (HAS_DWELL) begin
            state_n = HOLD_LO;
            dwl_n   = DW_INIT;
          end else begin
            state_n = UP;
            pos_n   = P_ONE;
            dir_n   = 1'b0;
          end
        end
        HOLD_LO: if (step) begin
          tick_n = 1'b1;
          if (dwl_q == '0) begin
            state_n = UP;
            pos_n   = P_ONE;
            dir_n   = 1'b0;
          end else begin
            dwl_n = dwl_q - 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    leds_n = '0;
    if (state_n != IDLE) begin
      leds_n = LED0 << pos_n;
    end
  end

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      pos_q  <= '0;
      o_dir  <= 1'b0;
      dwl_q  <= '0;
      o_tick <= 1'b0;
      o_leds <= '0;
      o_busy <= 1'b0;
    end else begin
      state  <= state_n;
      pos_q  <= pos_n;
      o_dir  <= dir_n;
      dwl_q  <= dwl_n;
      o_tick <= tick_n;
      o_leds <= leds_n;
      o_busy <= (state_n != IDLE);
    end
  end

  assign o_pos = pos_q;

endmodule

// File: tb/tb_larson_scan_ctrl.sv
// Bench for larson_scan_ctrl: three parameterisations, shared stimulus.
// Reference model feeds an expectation queue checked after each edge.
module tb_larson_scan_ctrl;

  localparam int S_ID = 0;
  localparam int S_UP = 1;
  localparam int S_HH = 2;
  localparam int S_DN = 3;
  localparam int S_HL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        wrap;
  logic [15:0] div;

  logic [3:0] a_leds;
  logic [1:0] a_pos;
  logic       a_dir, a_tick, a_busy;
  logic [3:0] b_leds;
  logic [1:0] b_pos;
  logic       b_dir, b_tick, b_busy;
  logic [7:0] c_leds;
  logic [2:0] c_pos;
  logic       c_dir, c_tick, c_busy;

  always #5 clk = ~clk;

  larson_scan_ctrl #(
    .N_LEDS(4), .DIV_W(16), .DWELL(0)
  ) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .i_div(div), .i_mode_wrap(wrap),
    .o_leds(a_leds), .o_pos(a_pos), .o_dir(a_dir),
    .o_tick(a_tick), .o_busy(a_busy)
  );

  larson_scan_ctrl #(
    .N_LEDS(4), .DIV_W(16), .DWELL(2)
  ) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .i_div(div), .i_mode_wrap(wrap),
    .o_leds(b_leds), .o_pos(b_pos), .o_dir(b_dir),
    .o_tick(b_tick), .o_busy(b_busy)
  );

  larson_scan_ctrl #(
    .N_LEDS(8), .DIV_W(16), .DWELL(0)
  ) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .i_div(div), .i_mode_wrap(wrap),
    .o_leds(c_leds), .o_pos(c_pos), .o_dir(c_dir),
    .o_tick(c_tick), .o_busy(c_busy)
  );

  typedef struct {
    int st; int pos; int dir;
    int cnt; int dwl; int tick;
  } mdl_t;

  typedef struct {
    int inst; int leds; int pos;
    int dir; int tick; int busy;
  } exp_t;

  mdl_t m [3];
  int   nl[3] = '{4, 4, 8};
  int   dw[3] = '{0, 2, 0};
  exp_t sb[$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic mdl_t nxt(mdl_t s, int n, int d);
    mdl_t r;
    bit   fire;
    r = s;
    r.tick = 0;
    if (!rst_n || !en) begin
      r = '{0, 0, 0, 0, 0, 0};
      return r;
    end
    if (s.st == S_ID) begin
      r = '{S_UP, 0, 0, 0, 0, 0};
      return r;
    end
    fire = (s.cnt >= int'(div));
    r.cnt = fire ? 0 : s.cnt + 1;
    if (!fire) return r;
    r.tick = 1;
    case (s.st)
      S_UP: begin
        if (s.pos < n - 1) r.pos = s.pos + 1;
        else if (wrap) r.pos = 0;
        else if (d > 0) begin
          r.st = S_HH; r.dwl = d - 1;
        end else begin
          r.st = S_DN; r.pos = n - 2; r.dir = 1;
        end
      end
      S_HH: begin
        if (s.dwl == 0) begin
          r.st = S_DN; r.pos = n - 2; r.dir = 1;
        end else r.dwl = s.dwl - 1;
      end
      S_DN: begin
        if (s.pos > 0) r.pos = s.pos - 1;
        else if (d > 0) begin
          r.st = S_HL; r.dwl = d - 1;
        end else begin
          r.st = S_UP; r.pos = 1; r.dir = 0;
        end
      end
      S_HL: begin
        if (s.dwl == 0) begin
          r.st = S_UP; r.pos = 1; r.dir = 0;
        end else r.dwl = s.dwl - 1;
      end
      default: r.st = S_ID;
    endcase
    return r;
  endfunction

  function automatic exp_t act(int i);
    exp_t g;
    g.inst = i;
    case (i)
      0: begin
        g.leds = a_leds; g.pos = a_pos; g.dir = a_dir;
        g.tick = a_tick; g.busy = a_busy;
      end
      1: begin
        g.leds = b_leds; g.pos = b_pos; g.dir = b_dir;
        g.tick = b_tick; g.busy = b_busy;
      end
      default: begin
        g.leds = c_leds; g.pos = c_pos; g.dir = c_dir;
        g.tick = c_tick; g.busy = c_busy;
      end
    endcase
    return g;
  endfunction

  task automatic step_clk();
    exp_t e;
    exp_t g;
    for (int i = 0; i < 3; i++) begin
      m[i]   = nxt(m[i], nl[i], dw[i]);
      e.inst = i;
      e.busy = (m[i].st != S_ID);
      e.leds = e.busy ? (1 << m[i].pos) : 0;
      e.pos  = m[i].pos;
      e.dir  = m[i].dir;
      e.tick = m[i].tick;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      g = act(e.inst);
      chk($sformatf("u%0d_leds", e.inst), g.leds, e.leds);
      chk($sformatf("u%0d_pos", e.inst), g.pos, e.pos);
      chk($sformatf("u%0d_dir", e.inst), g.dir, e.dir);
      chk($sformatf("u%0d_tick", e.inst), g.tick, e.tick);
      chk($sformatf("u%0d_busy", e.inst), g.busy, e.busy);
    end
  endtask

  initial begin
    int seq[$];
    int bnc_tbl[8];
    int dwl_tbl[11];
    bit hit;

    bnc_tbl = '{1, 2, 3, 2, 1, 0, 1, 2};
    dwl_tbl = '{1, 2, 3, 3, 3, 2, 1, 0, 0, 0, 1};
    for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0, 0, 0};

    rst_n = 1'b0;
    en    = 1'b1;
    wrap  = 1'b0;
    div   = 16'd3;

    // reset held with enable high
    repeat (3) step_clk();
    chk("rst_leds", a_leds, 0);
    chk("rst_busy", c_busy, 0);

    // release: one cycle to busy at position 0
    rst_n = 1'b1;
    step_clk();
    chk("rel_leds", a_leds, 4'h1);
    chk("rel_busy", a_busy, 1);

    // bounce sequence at div 3
    seq.delete();
    for (int k = 0; k < 40; k++) begin
      step_clk();
      if (a_tick) seq.push_back(int'(a_pos));
    end
    chk("bnc_cnt", seq.size() >= 8, 1);
    for (int k = 0; k < 8 && k < seq.size(); k++)
      chk($sformatf("bnc_seq%0d", k), seq[k], bnc_tbl[k]);

    // dwell of two at div 0
    en = 1'b0;
    step_clk();
    div = 16'd0;
    en  = 1'b1;
    step_clk();
    for (int k = 0; k < 11; k++) begin
      step_clk();
      chk($sformatf("dwl_seq%0d", k), b_pos, dwl_tbl[k]);
    end
    for (int k = 0; k < 20; k++) step_clk();

    // wrap at div 1
    en = 1'b0;
    step_clk();
    div  = 16'd1;
    wrap = 1'b1;
    en   = 1'b1;
    for (int k = 0; k < 40; k++) step_clk();

    // switch to bounce mid run, then abort in DOWN
    wrap = 1'b0;
    en   = 1'b0;
    step_clk();
    div = 16'd3;
    en  = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      if (m[0].st == S_DN && m[0].pos == 2 &&
          m[0].cnt == 3)
        hit = 1'b1;
      else
        step_clk();
    end
    chk("abort_reach", hit, 1);
    en = 1'b0;
    step_clk();
    chk("abort_tick", a_tick, 0);
    chk("abort_leds", a_leds, 0);
    en = 1'b1;
    step_clk();
    chk("reen_pos", a_pos, 0);
    chk("reen_dir", a_dir, 0);

    // live divider drop from 9 to 2 at cnt 5
    en = 1'b0;
    step_clk();
    div = 16'd9;
    en  = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      if (m[0].st != S_ID && m[0].cnt == 5)
        hit = 1'b1;
      else
        step_clk();
    end
    chk("live_reach", hit, 1);
    div = 16'd2;
    step_clk();
    chk("live_t0", a_tick, 1);
    step_clk();
    step_clk();
    chk("live_t2", a_tick, 0);
    step_clk();
    chk("live_t3", a_tick, 1);

    // mixed random traffic
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 19) != 0);
      rst_n = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 15) == 0) wrap = ~wrap;
      if ($urandom_range(0, 7) == 0)
        div = 16'($urandom_range(0, 4));
      step_clk();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
